// File: rtl/decode_cycle_if.sv
// Decode-stage bundle: fetch/writeback/hazard inputs and registered ID/EX outputs.
// Latency: none (wires only); the decode_cycle module owns all timing.
// Backpressure: none; the pipeline advances every cycle, and FlushE inserts bubbles.
interface decode_cycle_if #(parameter int XLEN = 32);
  logic [31:0]      InstrD;
  logic [XLEN-1:0]  PCD;
  logic [XLEN-1:0]  PCPlus4D;
  logic             RegWriteW;
  logic [4:0]       RDW;
  logic [XLEN-1:0]  ResultW;
  logic             FlushE;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             MemWriteE;
  logic             JumpE;
  logic             BranchE;
  logic [2:0]       ALUControlE;
  logic             ALUSrcE;
  logic [XLEN-1:0]  RD1E;
  logic [XLEN-1:0]  RD2E;
  logic [XLEN-1:0]  ImmExtE;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [XLEN-1:0]  PCE;
  logic [XLEN-1:0]  PCPlus4E;

  // Fetch/writeback/hazard side
  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
           ALUControlE, ALUSrcE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );

  // Decode stage
  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
           ALUControlE, ALUSrcE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I-subset decode: register file with write-through, main/ALU decode, immediate extend, ID/EX register.
// Latency: 1 cycle from InstrD to the E-stage outputs; Rs1D/Rs2D are combinational.
// Backpressure: none; FlushE turns the next ID/EX contents into a bubble without blocking writeback.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

  logic [XLEN-1:0] rf [NREGS];

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;

  logic            reg_write;
  logic [1:0]      result_src;
  logic            mem_write;
  logic            jump;
  logic            branch;
  logic [2:0]      alu_control;
  logic            alu_src;
  imm_src_t        imm_src;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [2:0]      op_alu;
  logic            op_ok;

  assign instr  = bus.InstrD;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign bus.Rs1D = rs1;
  assign bus.Rs2D = rs2;

  // Register file: cleared by reset, written from writeback; x0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.RegWriteW && (bus.RDW != 5'd0)) begin
      rf[bus.RDW] <= bus.ResultW;
    end
  end

  // Read ports: x0 reads zero, same-cycle writeback to the source register bypasses the array.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (bus.RegWriteW && bus.RDW == rs1) ? bus.ResultW : rf[rs1];
    if (rs2 != 5'd0) rd2 = (bus.RegWriteW && bus.RDW == rs2) ? bus.ResultW : rf[rs2];
  end

  // funct3 -> ALU op shared by R-type and OP-IMM; op_ok=0 marks unsupported funct3.
  always_comb begin
    op_alu = ALU_ADD;
    op_ok  = 1'b1;
    case (funct3)
      3'b000:  op_alu = ALU_ADD;
      3'b110:  op_alu = ALU_OR;
      3'b111:  op_alu = ALU_AND;
      3'b010:  op_alu = ALU_SLT;
      default: op_ok  = 1'b0;
    endcase
  end

  // Main decode: anything unrecognised (including all-zero fetch filler) leaves every control at 0.
  always_comb begin
    reg_write   = 1'b0;
    result_src  = 2'b00;
    mem_write   = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    alu_control = ALU_ADD;
    alu_src     = 1'b0;
    imm_src     = IMM_NONE;
    case (opcode)
      OP_R: if (op_ok) begin
        reg_write   = 1'b1;
        alu_control = (funct3 == 3'b000 && instr[30]) ? ALU_SUB : op_alu;
      end
      OP_IMM: if (op_ok) begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = op_alu;
        imm_src     = IMM_I;
      end
      OP_LOAD: if (funct3 == 3'b010) begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        alu_src    = 1'b1;
        imm_src    = IMM_I;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_src   = IMM_S;
      end
      OP_BR: if (funct3 == 3'b000) begin
        branch      = 1'b1;
        alu_control = ALU_SUB;
        imm_src     = IMM_B;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b10;
        jump       = 1'b1;
        imm_src    = IMM_J;
      end
      default: ;
    endcase
  end

  // Immediate extender selected by instruction format.
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ID/EX register: reset or flush loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUControlE <= 3'b000;
      bus.ALUSrcE     <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.Rs1E        <= '0;
      bus.Rs2E        <= '0;
      bus.RdE         <= '0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
    end else if (bus.FlushE) begin
      bus.RegWriteE   <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUControlE <= 3'b000;
      bus.ALUSrcE     <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.ImmExtE     <= '0;
      bus.Rs1E        <= '0;
      bus.Rs2E        <= '0;
      bus.RdE         <= '0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
    end else begin
      bus.RegWriteE   <= reg_write;
      bus.ResultSrcE  <= result_src;
      bus.MemWriteE   <= mem_write;
      bus.JumpE       <= jump;
      bus.BranchE     <= branch;
      bus.ALUControlE <= alu_control;
      bus.ALUSrcE     <= alu_src;
      bus.RD1E        <= rd1;
      bus.RD2E        <= rd2;
      bus.ImmExtE     <= imm_ext;
      bus.Rs1E        <= rs1;
      bus.Rs2E        <= rs2;
      bus.RdE         <= rd;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: reset, regfile write/read, write-through, x0, immediates, decode, flush.
// Inputs change #1 after a rising edge; outputs are checked #1 after the edge that registers them.
// Each check is an immediate assertion that counts failures for the summary line.
module tb_decode_cycle;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  decode_cycle_if bus ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control bundle {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc} as 10 bits.
  function automatic logic [31:0] ctl(input logic rw, input logic [1:0] rs, input logic mw,
                                      input logic j, input logic b, input logic [2:0] alu,
                                      input logic as);
    return {22'd0, rw, rs, mw, j, b, alu, as};
  endfunction

  function automatic logic [31:0] ctl_e();
    return {22'd0, bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
            bus.ALUControlE, bus.ALUSrcE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic we, input logic [4:0] rdw,
                       input logic [31:0] res, input logic flush);
    bus.InstrD    = instr;
    bus.RegWriteW = we;
    bus.RDW       = rdw;
    bus.ResultW   = res;
    bus.FlushE    = flush;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.PCD      = 32'h0;
    bus.PCPlus4D = 32'h4;
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

    // 1: reset held 3 cycles with random instructions
    for (int c = 0; c < 3; c++) begin
      bus.InstrD = $urandom;
      tick();
    end
    chk("rst_ctl", ctl_e(), 32'h0);
    chk("rst_rd1", bus.RD1E, 32'h0);
    chk("rst_rd2", bus.RD2E, 32'h0);
    chk("rst_imm", bus.ImmExtE, 32'h0);
    chk("rst_rd",  {27'd0, bus.RdE}, 32'h0);
    chk("rst_pc",  bus.PCE, 32'h0);
    chk("rst_pc4", bus.PCPlus4E, 32'h0);
    rst = 1'b1;
    // every register reads zero after reset: add x1,xr,xr for r=1..31
    for (int r = 1; r < 32; r++) begin
      logic [31:0] ins;
      ins = 32'h00000033;
      ins[24:20] = 5'(r);
      ins[19:15] = 5'(r);
      ins[11:7]  = 5'd1;
      drive(ins, 1'b0, 5'd0, 32'h0, 1'b0);
      tick();
      chk("rf_clear_rd1", bus.RD1E, 32'h0);
      chk("rf_clear_rs1", {27'd0, bus.Rs1E}, 32'(r));
    end

    // 2: writeback x5 then add x6,x5,x5
    drive(32'h0, 1'b1, 5'd5, 32'h00001234, 1'b0);
    tick();
    chk("nop_ctl", ctl_e(), 32'h0);
    drive(32'h00528333, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("rs1d", {27'd0, bus.Rs1D}, 32'd5);
    chk("rs2d", {27'd0, bus.Rs2D}, 32'd5);
    tick();
    chk("add_rd1", bus.RD1E, 32'h1234);
    chk("add_rd2", bus.RD2E, 32'h1234);
    chk("add_rd",  {27'd0, bus.RdE}, 32'd6);
    chk("add_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));

    // 3: write-through in the same cycle
    drive(32'h00528333, 1'b1, 5'd5, 32'h0000CAFE, 1'b0);
    tick();
    chk("wt_rd1", bus.RD1E, 32'hCAFE);
    chk("wt_rd2", bus.RD2E, 32'hCAFE);

    // 4: x0 write ignored, also not bypassed when it coincides with the read
    drive(32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    tick();
    drive(32'hFFF00093, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    tick();
    chk("x0_rd1", bus.RD1E, 32'h0);
    chk("addi_imm", bus.ImmExtE, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, bus.RdE}, 32'd1);
    chk("addi_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1));

    // 5: beq x1,x2,-8 with PCs forwarded
    bus.PCD = 32'h00000100;
    bus.PCPlus4D = 32'h00000104;
    drive(32'hFE208CE3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("beq_imm", bus.ImmExtE, 32'hFFFFFFF8);
    chk("beq_ctl", ctl_e(), ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0));
    chk("beq_pc",  bus.PCE, 32'h100);
    chk("beq_pc4", bus.PCPlus4E, 32'h104);

    // other decodes: sub, slti, sw, jal, and, unsupported funct3
    drive(32'h405303B3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("sub_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0));
    chk("sub_rd2", bus.RD2E, 32'hCAFE);
    drive(32'h0052A413, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("slti_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b101, 1'b1));
    chk("slti_imm", bus.ImmExtE, 32'd5);
    drive(32'h00512623, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("sw_ctl", ctl_e(), ctl(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1));
    chk("sw_imm", bus.ImmExtE, 32'd12);
    chk("sw_rd2", bus.RD2E, 32'hCAFE);
    drive(32'hFFDFF0EF, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("jal_ctl", ctl_e(), ctl(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0));
    chk("jal_imm", bus.ImmExtE, 32'hFFFFFFFC);
    drive(32'h0052F4B3, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("and_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0));
    drive(32'h00529333, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("illegal_ctl", ctl_e(), 32'h0);

    // 6: lw normally, then lw flushed while x7 is written back
    drive(32'h0042A503, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("lw_ctl", ctl_e(), ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1));
    chk("lw_imm", bus.ImmExtE, 32'd4);
    chk("lw_rd",  {27'd0, bus.RdE}, 32'd10);
    drive(32'h0042A503, 1'b1, 5'd7, 32'h00000077, 1'b1);
    tick();
    chk("flush_ctl", ctl_e(), 32'h0);
    chk("flush_rd",  {27'd0, bus.RdE}, 32'd0);
    chk("flush_rs1", {27'd0, bus.Rs1E}, 32'd0);
    chk("flush_rd1", bus.RD1E, 32'h0);
    drive(32'h00738333, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("flush_wb_rd1", bus.RD1E, 32'h77);
    chk("flush_wb_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));

    // reset mid-stream clears outputs without waiting for an edge, and clears the regfile
    rst = 1'b0;
    #1;
    chk("midrst_ctl", ctl_e(), 32'h0);
    chk("midrst_rd1", bus.RD1E, 32'h0);
    chk("midrst_pc",  bus.PCE, 32'h0);
    tick();
    rst = 1'b1;
    drive(32'h00528333, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    chk("postrst_rd1", bus.RD1E, 32'h0);
    chk("postrst_ctl", ctl_e(), ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    chk("postrst_rd", {27'd0, bus.RdE}, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
